// File: rtl/sap1e_pkg.sv
// Shared constants and helpers for the CPU output-port display:
// segment codes, converter FSM encoding and the double-dabble step.
package sap1e_pkg;

    // Active-low {g,f,e,d,c,b,a} segment patterns
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    localparam int DATA_W     = 8;
    localparam int BCD_DIGITS = 3;
    localparam int DBL_W      = DATA_W + 4 * BCD_DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                   input logic              neg);
        return neg ? (~v + 8'd1) : v;
    endfunction

    // One double-dabble iteration on {bcd, binary}: add-3 correction, then shift
    function automatic logic [DBL_W-1:0] dabble_step(input logic [DBL_W-1:0] acc);
        logic [DBL_W-1:0] adj;
        adj = acc;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (adj[DATA_W + 4*d +: 4] >= 4'd5)
                adj[DATA_W + 4*d +: 4] = adj[DATA_W + 4*d +: 4] + 4'd3;
        end
        return {adj[DBL_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/out_display_seg7_decode.sv
// Combinational BCD digit to active-low 7-segment pattern, with a blank override.
module seg7_decode
    import sap1e_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        // NOTE: a default on every combinational output keeps unlisted codes from inferring a latch.
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            case (i_bcd)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/out_display.sv
// CPU output-port display: binary-to-BCD conversion on value change and
// a multiplexed 4-digit 7-segment scan with optional leading minus.
module out_display
    import sap1e_pkg::*;
#(
    parameter int REFRESH_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] out_in,
    input  logic       signed_mode,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       busy
);

    localparam int               PRE_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

    conv_state_t      r_state;
    conv_state_t      w_next_state;
    logic [7:0]       r_shadow;
    logic             r_shadow_mode;
    logic [DBL_W-1:0] r_acc;
    logic [2:0]       r_count;
    logic             r_neg;
    logic [3:0]       r_disp_h;
    logic [3:0]       r_disp_t;
    logic [3:0]       r_disp_o;
    logic             r_disp_neg;
    logic [PRE_W-1:0] r_pre;
    logic [1:0]       r_idx;
    logic [6:0]       r_seg;
    logic [3:0]       r_an;

    logic             w_change;
    logic             w_in_neg;
    logic             w_shift_last;
    logic [3:0]       w_bcd;
    logic             w_blank;
    logic [6:0]       w_dec_seg;
    logic [6:0]       w_seg_next;

    assign w_change     = (out_in != r_shadow) || (signed_mode != r_shadow_mode);
    assign w_in_neg     = signed_mode & out_in[7];
    assign w_shift_last = (r_count == 3'd7);

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_change)     w_next_state = ST_SHIFT;
            ST_SHIFT: if (w_shift_last) w_next_state = ST_DONE;
            ST_DONE:                    w_next_state = ST_IDLE;
            default:                    w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != ST_IDLE);
    end

    // Shadows are only reloaded in IDLE, so edits during a conversion wait their turn
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow      <= 8'h00;
            r_shadow_mode <= 1'b0;
            r_acc         <= '0;
            r_count       <= 3'd0;
            r_neg         <= 1'b0;
            r_disp_h      <= 4'd0;
            r_disp_t      <= 4'd0;
            r_disp_o      <= 4'd0;
            r_disp_neg    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_change) begin
                        r_shadow      <= out_in;
                        r_shadow_mode <= signed_mode;
                        r_acc         <= {12'h000, magnitude(out_in, w_in_neg)};
                        r_neg         <= w_in_neg;
                        r_count       <= 3'd0;
                    end
                end
                ST_SHIFT: begin
                    r_acc   <= dabble_step(r_acc);
                    r_count <= r_count + 3'd1;
                end
                ST_DONE: begin
                    r_disp_h   <= r_acc[19:16];
                    r_disp_t   <= r_acc[15:12];
                    r_disp_o   <= r_acc[11:8];
                    r_disp_neg <= r_neg;
                end
                default: ;
            endcase
        end
    end

    // Leading-zero suppression: tens hide only when hundreds are also zero
    always_comb begin
        w_bcd   = r_disp_o;
        w_blank = 1'b0;
        case (r_idx)
            2'd0: begin
                w_bcd   = r_disp_o;
                w_blank = 1'b0;
            end
            2'd1: begin
                w_bcd   = r_disp_t;
                w_blank = (r_disp_h == 4'd0) && (r_disp_t == 4'd0);
            end
            2'd2: begin
                w_bcd   = r_disp_h;
                w_blank = (r_disp_h == 4'd0);
            end
            default: begin
                w_bcd   = 4'd0;
                w_blank = 1'b1;
            end
        endcase
    end

    seg7_decode u_decode (
        .i_bcd   (w_bcd),
        .i_blank (w_blank),
        .o_seg   (w_dec_seg)
    );

    assign w_seg_next = (r_idx == 2'd3) ? (r_disp_neg ? SEG_MINUS : SEG_BLANK) : w_dec_seg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre <= '0;
            r_idx <= 2'd0;
            r_seg <= SEG_BLANK;
            r_an  <= 4'hF;
        end else begin
            if (r_pre == PRE_LAST) begin
                r_pre <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_pre <= r_pre + PRE_W'(1);
            end
            r_seg <= w_seg_next;
            r_an  <= ~(4'b0001 << r_idx);
        end
    end

    assign seg = r_seg;
    assign an  = r_an;

endmodule

// File: tb/tb_out_display.sv
// Scoreboard bench for out_display: stimulus queues expected digit patterns,
// a monitor compares a full scan after each conversion completes.
module tb_out_display;

    localparam int DIV = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] out_in;
    logic       signed_mode;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy;

    out_display #(.REFRESH_DIV(DIV)) dut (
        .clk         (clk),
        .reset       (reset),
        .out_in      (out_in),
        .signed_mode (signed_mode),
        .seg         (seg),
        .an          (an),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [27:0] segs;   // {idx3, idx2, idx1, idx0}
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    event conv_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] next_an(input logic [3:0] a);
        case (a)
            4'hE:    return 4'hD;
            4'hD:    return 4'hB;
            4'hB:    return 4'h7;
            default: return 4'hE;
        endcase
    endfunction

    // One full scan period of samples, sorted by which digit is enabled
    task automatic capture_scan(output logic [27:0] segs, output logic [3:0] seen);
        segs = '1;
        seen = 4'h0;
        for (int i = 0; i < 4 * DIV; i++) begin
            @(negedge clk);
            case (an)
                4'hE: begin segs[6:0]   = seg; seen[0] = 1'b1; end
                4'hD: begin segs[13:7]  = seg; seen[1] = 1'b1; end
                4'hB: begin segs[20:14] = seg; seen[2] = 1'b1; end
                4'h7: begin segs[27:21] = seg; seen[3] = 1'b1; end
                default: ;
            endcase
        end
    endtask

    // Busy-pulse width checker; a completed pulse signals the monitor
    initial begin
        int busy_cnt;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_cnt = 0;
            end else if (busy) begin
                busy_cnt++;
            end else if (busy_cnt != 0) begin
                check("busy_len", busy_cnt, 9);
                busy_cnt = 0;
                -> conv_done;
            end
        end
    end

    // Monitor: compare the displayed digits against the oldest expectation
    initial begin
        exp_t        e;
        logic [27:0] got;
        logic [3:0]  seen;
        forever begin
            @(conv_done);
            capture_scan(got, seen);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_conv: got %0h expected none", got);
            end else begin
                e = sb.pop_front();
                check({e.name, "_seen"}, seen, 4'hF);
                check(e.name, got, e.segs);
            end
        end
    end

    task automatic apply(input string name, input logic [7:0] v, input logic m,
                         input logic [27:0] segs, input int cycles);
        out_in      = v;
        signed_mode = m;
        sb.push_back('{name, segs});
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        logic [3:0] an_hist [24];
        logic [6:0] seg_hist[24];
        int         idle_busy;
        int         bad_digit;
        int         bad_order;
        int         bad_run;
        int         n_trans;
        int         last_t;

        reset       = 1'b1;
        out_in      = 8'd0;
        signed_mode = 1'b0;
        #1;
        check("rst_seg", seg, 7'h7F);
        check("rst_an", an, 4'hF);
        check("rst_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_hold_seg", seg, 7'h7F);
        check("rst_hold_an", an, 4'hF);
        reset = 1'b0;

        // Idle after reset: "   0" with a clean E,D,B,7 rotation
        idle_busy = 0;
        bad_digit = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            an_hist[i]  = an;
            seg_hist[i] = seg;
            if (busy) idle_busy++;
            if (seg !== ((an == 4'hE) ? 7'h40 : 7'h7F)) bad_digit++;
        end
        check("idle_busy", idle_busy, 0);
        check("idle_digits", bad_digit, 0);
        bad_order = 0;
        bad_run   = 0;
        n_trans   = 0;
        last_t    = -1;
        for (int i = 1; i < 24; i++) begin
            if (an_hist[i] !== an_hist[i-1]) begin
                if (an_hist[i] !== next_an(an_hist[i-1])) bad_order++;
                if (last_t >= 0 && (i - last_t) != DIV) bad_run++;
                last_t = i;
                n_trans++;
            end
        end
        check("an_order", bad_order, 0);
        check("an_dwell", bad_run, 0);
        check("an_transitions", n_trans, 11);

        // Unsigned 255 with explicit busy edges
        out_in = 8'd255;
        #1 check("t2_busy_before", busy, 1'b0);
        sb.push_back('{"t2_255", {7'h7F, 7'h24, 7'h12, 7'h12}});
        @(negedge clk);
        check("t2_busy_after", busy, 1'b1);
        repeat (30) @(negedge clk);

        apply("t3_neg10",   8'hF6, 1'b1, {7'h3F, 7'h7F, 7'h79, 7'h40}, 30);
        apply("t4_neg128",  8'h80, 1'b1, {7'h3F, 7'h79, 7'h24, 7'h00}, 30);
        apply("t4_pos128",  8'h80, 1'b0, {7'h7F, 7'h79, 7'h24, 7'h00}, 30);
        apply("s_pos127",   8'h7F, 1'b1, {7'h7F, 7'h79, 7'h24, 7'h78}, 30);
        apply("s_neg1",     8'hFF, 1'b1, {7'h3F, 7'h7F, 7'h7F, 7'h79}, 30);
        apply("u_100",      8'd100, 1'b0, {7'h7F, 7'h79, 7'h40, 7'h40}, 30);
        apply("u_5",        8'd5,  1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 30);
        apply("u_0",        8'd0,  1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 30);

        // Change during busy is picked up once IDLE
        apply("t5_42",      8'd42, 1'b0, {7'h7F, 7'h7F, 7'h19, 7'h24}, 3);
        apply("t5_7",       8'd7,  1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 40);

        // Only the last of several mid-conversion values is shown
        apply("t5b_33",     8'd33, 1'b0, {7'h7F, 7'h7F, 7'h30, 7'h30}, 2);
        out_in = 8'd44;
        repeat (2) @(negedge clk);
        apply("t5b_55",     8'd55, 1'b0, {7'h7F, 7'h7F, 7'h12, 7'h12}, 40);

        // Asynchronous reset in the middle of SHIFT
        out_in = 8'd200;
        repeat (3) @(negedge clk);
        check("t6_busy_pre", busy, 1'b1);
        #2 reset = 1'b1;
        out_in = 8'd9;
        #1;
        check("t6_async_seg", seg, 7'h7F);
        check("t6_async_an", an, 4'hF);
        check("t6_async_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        sb.push_back('{"t6_9", {7'h7F, 7'h7F, 7'h7F, 7'h10}});
        reset = 1'b0;
        repeat (30) @(negedge clk);

        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
